// File: rtl/pdm_decoder.sv
// pdm_decoder
//   Integrate-and-dump decimator that turns a 1-bit PDM stream back into a
//   10-bit amplitude sample. It counts the ones over a window of DECIM
//   qualified bits and emits that count as one sample, on the same 0..1023
//   scale as the wave source that feeds the modulator.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-low reset
//   enable        run enable; low parks the FSM in IDLE and drops the window
//   pdm_in        PDM bit (clk domain)
//   pdm_en        qualifier; pdm_in is consumed only when high
//   sample_out    ones count of the last completed window (0..DECIM)
//   sample_valid  sample_out holds an unconsumed sample
//   sample_ready  consumer accept; valid&ready at posedge consumes the sample
//   overrun       sticky: a new sample replaced an unconsumed one
//   overrun_clr   clears overrun (a same-edge overrun wins)
module pdm_decoder #(
  parameter int DECIM = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pdm_in,
  input  logic       pdm_en,
  output logic [9:0] sample_out,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun,
  input  logic       overrun_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [9:0] LAST_BIT = 10'(DECIM - 1);

  state_t     state_q, state_d;
  logic [9:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] ones_cnt_q, ones_cnt_d;
  logic [9:0] sample_out_q, sample_out_d;
  logic       sample_valid_q, sample_valid_d;
  logic       overrun_q, overrun_d;
  logic       complete;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    ones_cnt_d     = ones_cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    complete       = 1'b0;

    case (state_q)
      IDLE: begin
        // The edge that first sees enable only arms the FSM; no bit is taken.
        bit_cnt_d  = '0;
        ones_cnt_d = '0;
        if (enable) state_d = ACCUM;
      end
      ACCUM: begin
        if (!enable) begin
          // Dropping enable discards the partial window without a sample.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
        end else if (pdm_en) begin
          if (bit_cnt_q == LAST_BIT) begin
            // Last bit of the window: dump and restart with no gap bit.
            complete   = 1'b1;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
          end else begin
            bit_cnt_d  = bit_cnt_q + 10'd1;
            ones_cnt_d = ones_cnt_q + {9'd0, pdm_in};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The final bit is folded in directly so the sample lands one cycle
    // after the last bit is consumed.
    if (complete) begin
      sample_out_d   = ones_cnt_q + {9'd0, pdm_in};
      sample_valid_d = 1'b1;
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end

    // Set has priority over clear so a same-edge overrun is never lost.
    if (complete && sample_valid_q && !sample_ready) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      ones_cnt_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      ones_cnt_q     <= ones_cnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule
